// File: rtl/fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit_if : instruction-memory, redirect and decode-side bundle of fetch
// Rev 1.0
// ----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode,
    input  imem_valid, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode,
    output imem_valid, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit : RV32 fetch stage, one outstanding request, 2-entry instr FIFO;
// optional misaligned-redirect trap under FETCH_MISALIGN_TRAP_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic         misalign_err
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_HALT  = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [1:0]  count;
  logic [31:0] head_instr;
  logic [31:0] head_pc;
  logic [31:0] tail_instr;
  logic [31:0] tail_pc;

  logic        issue;
  logic        push;
  logic        pop;
  logic        flush;
  logic [31:0] tgt_pc;

  // A request needs FETCH, room for its response, and no competing redirect.
  assign issue = (state == S_FETCH) && !bus.redirect && (count != 2'd2) && !rst;
  assign push  = (state == S_WAIT) && bus.imem_valid && !bus.redirect;
  assign pop   = (count != 2'd0) && bus.id_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic bad_tgt;
  assign tgt_pc  = bus.redirect_pc;
  assign bad_tgt = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
  assign flush   = bus.redirect && (state != S_HALT);
`else
  assign tgt_pc  = bus.redirect_pc & ~32'h0000_0003;
  assign flush   = bus.redirect;
`endif

  assign bus.imem_req  = issue;
  assign bus.imem_addr = (state == S_FETCH) ? fetch_pc : req_pc;
  assign bus.id_valid  = (count != 2'd0);
  assign bus.id_instr  = head_instr;
  assign bus.id_pc     = head_pc;
  assign bus.id_opcode = head_instr[6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      count      <= 2'd0;
      head_instr <= 32'd0;
      head_pc    <= 32'd0;
      tail_instr <= 32'd0;
      tail_pc    <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      if (flush)
        count <= 2'd0;
      else if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;

      // A flushed FIFO keeps the head registers frozen at their last value.
      if (!flush) begin
        if (pop && (count == 2'd2)) begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
        end
        if (push) begin
          if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
            head_instr <= bus.imem_rdata;
            head_pc    <= req_pc;
          end else begin
            tail_instr <= bus.imem_rdata;
            tail_pc    <= req_pc;
          end
        end
      end

      case (state)
        S_FETCH: begin
          if (bus.redirect) begin
            fetch_pc <= tgt_pc;
          end else if (issue) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.redirect) begin
            fetch_pc <= tgt_pc;
            state    <= bus.imem_valid ? S_FETCH : S_DROP;
          end else if (bus.imem_valid) begin
            state <= S_FETCH;
          end
        end
        S_DROP: begin
          if (bus.redirect)
            fetch_pc <= tgt_pc;
          if (bus.imem_valid)
            state <= S_FETCH;
        end
        default: begin
        end
      endcase

`ifdef FETCH_MISALIGN_TRAP_EN
      // Trap wins over whatever transition the redirect would otherwise take;
      // any response still in flight lands in HALT and is ignored there.
      if (bad_tgt && (state != S_HALT)) begin
        misalign_err <= 1'b1;
        state        <= S_HALT;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_unit : directed scoreboard bench for fetch_unit with a memory model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk;
  logic rst;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_err;
`endif

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  ent_t        q[$];
  logic [31:0] req_log[$];
  int          mem_lat  = 1;
  bit          pending  = 0;
  bit          stale    = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT at negedge (scoreboard + memory bookkeeping), then
  // drive the memory response just after the rising edge.
  task automatic cyc();
    ent_t e;
    @(negedge clk);
    if (!rst) begin
      if (bus.id_valid && bus.id_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_pop", {31'd0, bus.id_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_instr", bus.id_instr, e.instr);
          chk("sb_pc", bus.id_pc, e.pc);
          chk("sb_opcode", {25'd0, bus.id_opcode}, {25'd0, e.instr[6:0]});
        end
      end
      if (bus.imem_valid) begin
        if (!bus.redirect && !stale)
          q.push_back('{instr: data_of(pend_addr), pc: pend_addr});
        pending = 0;
        stale   = 0;
      end
      if (bus.redirect) begin
        q.delete();
        if (pending)
          stale = 1;
      end
      if (bus.imem_req) begin
        if (pending)
          chk("second_outstanding", {31'd0, bus.imem_req}, 32'd0);
        pending   = 1;
        pend_addr = bus.imem_addr;
        pend_cnt  = mem_lat;
        req_log.push_back(bus.imem_addr);
      end
    end
    @(posedge clk);
    #1;
    bus.imem_valid = 1'b0;
    if (rst) begin
      pending = 0;
      stale   = 0;
      q.delete();
      req_log.delete();
    end else if (pending) begin
      if (pend_cnt <= 1) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = data_of(pend_addr);
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 60) begin cyc(); n++; end
    chk(tag, 32'(n < 60), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.imem_valid !== 1'b1 && n < 60) begin cyc(); n++; end
    chk(tag, 32'(n < 60), 32'd1);
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input string tag);
    int n = 0;
    while (!(bus.imem_req === 1'b1 && bus.imem_addr === a) && n < 60) begin cyc(); n++; end
    chk(tag, 32'(n < 60), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    rst             = 1'b1;
    bus.id_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.imem_valid  = 1'b0;
    bus.imem_rdata  = 32'd0;

    // Reset state
    run(3);
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'h100);
    chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_id_instr", bus.id_instr, 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'd0);
    chk("rst_id_opcode", {25'd0, bus.id_opcode}, 32'd0);

    // First request in cycle 0, data at decode two cycles later
    rst = 1'b0;
    #1;
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h100);
    cyc();
    chk("lat_c1_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("lat_c1_req_low", {31'd0, bus.imem_req}, 32'd0);
    cyc();
    chk("lat_c2_id_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("lat_c2_id_pc", bus.id_pc, 32'h100);
    chk("lat_c2_next_addr", bus.imem_addr, 32'h104);
    run(4);
    chk("seq_req0", req_log[0], 32'h100);
    chk("seq_req1", req_log[1], 32'h104);
    chk("seq_req2", req_log[2], 32'h108);

    // Back-pressure: FIFO fills to exactly two, then requests stop
    bus.id_ready = 1'b0;
    run(10);
    chk("stall_buffered", 32'(q.size()), 32'd2);
    chk("stall_req_low", {31'd0, bus.imem_req}, 32'd0);
    chk("stall_id_valid", {31'd0, bus.id_valid}, 32'd1);
    bus.id_ready = 1'b1;
    run(8);

    // Redirect with the 0x108 response outstanding on a 3-cycle memory
    mem_lat = 3;
    do_reset();
    wait_req_addr(32'h108, "wait_req_108");
    cyc();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    cyc();
    bus.redirect = 1'b0;
    wait_valid("wait_stale_valid");
    cyc();
    chk("drop_next_req", {31'd0, bus.imem_req}, 32'd1);
    chk("drop_next_addr", bus.imem_addr, 32'h200);
    chk("drop_id_valid", {31'd0, bus.id_valid}, 32'd0);
    run(6);

    // Redirect coincident with the response
    wait_valid("wait_coinc_valid");
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    cyc();
    bus.redirect = 1'b0;
    #1;
    chk("coinc_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("coinc_req", {31'd0, bus.imem_req}, 32'd1);
    chk("coinc_addr", bus.imem_addr, 32'h300);
    run(10);

    // Address wrap, also recovery with nothing outstanding
    wait_req("wait_req_wrap");
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    bus.redirect = 1'b0;
    #1;
    chk("wrap_req", {31'd0, bus.imem_req}, 32'd1);
    chk("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    cyc();
    wait_req("wait_req_after_wrap");
    chk("wrap_addr_zero", bus.imem_addr, 32'h0000_0000);
    run(8);

    // Misaligned redirect target
    wait_req("wait_req_mis");
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h202;
    cyc();
    bus.redirect = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_err_set", {31'd0, misalign_err}, 32'd1);
    chk("mis_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("mis_req_low", {31'd0, bus.imem_req}, 32'd0);
    n_before = req_log.size();
    run(10);
    chk("mis_no_reqs", 32'(req_log.size()), 32'(n_before));
    chk("mis_err_sticky", {31'd0, misalign_err}, 32'd1);
    do_reset();
    chk("mis_err_cleared", {31'd0, misalign_err}, 32'd0);
    chk("mis_restart_req", {31'd0, bus.imem_req}, 32'd1);
    chk("mis_restart_addr", bus.imem_addr, 32'h100);
`else
    n_before = req_log.size();
    chk("mis_req", {31'd0, bus.imem_req}, 32'd1);
    chk("mis_addr_aligned", bus.imem_addr, 32'h200);
    run(8);
    chk("mis_progress", 32'(req_log.size() > n_before), 32'd1);
`endif
    run(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
